// File: rtl/sudoku_pkg.sv
// ---------------------------------------------------------------------------
// sudoku_pkg
//   Definitions shared by the Sudoku direction controller and the cursor
//   position counter.
//   - GRID_N_DEFAULT : default board side length in cells
//   - DIR_*          : bit positions inside the 4-bit direction word
//   - grid_mul       : constant-coefficient multiply, built as shift-add
// ---------------------------------------------------------------------------
package sudoku_pkg;

  localparam int GRID_N_DEFAULT = 9;

  // Direction word layout: {y_up, y_en, x_up, x_en}
  localparam int DIR_X_EN = 0;
  localparam int DIR_X_UP = 1;
  localparam int DIR_Y_EN = 2;
  localparam int DIR_Y_UP = 3;

  // v * n where n is an elaboration-time constant. Only the set bits of n
  // contribute a shifted copy of v, so this reduces to a few adders and
  // never to a general multiplier or divider.
  function automatic logic [31:0] grid_mul(input logic [31:0] v,
                                           input logic [31:0] n);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (n[i]) acc = acc + (v << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/cursor_position_counter_if.sv
// ---------------------------------------------------------------------------
// cursor_position_counter_if
//   Bundle between the cursor position counter and its neighbours.
//   Inputs to the counter : dir[3:0], step, home
//   Outputs of the counter: col, row, cell_idx, move_pulse, wrap_pulse,
//                           blocked_pulse
//   modport master : the side that drives dir/step/home (controller, bench)
//   modport slave  : the cursor position counter itself
// ---------------------------------------------------------------------------
interface cursor_position_counter_if #(
  parameter int CW = 4,
  parameter int IW = 7
);

  logic [3:0]    dir;
  logic          step;
  logic          home;
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic [IW-1:0] cell_idx;
  logic          move_pulse;
  logic          wrap_pulse;
  logic          blocked_pulse;

  modport master (
    output dir, step, home,
    input  col, row, cell_idx, move_pulse, wrap_pulse, blocked_pulse
  );

  modport slave (
    input  dir, step, home,
    output col, row, cell_idx, move_pulse, wrap_pulse, blocked_pulse
  );

endinterface

// File: rtl/cursor_position_counter_axis.sv
// ---------------------------------------------------------------------------
// axis_step_counter
//   Purely combinational next-value logic for one cursor axis.
//   Ports:
//     cur       in  W  current registered position (0..N-1)
//     en        in  1  this axis takes part in the move
//     up        in  1  1 = increment, 0 = decrement
//     req       in  1  a move request is being applied this cycle
//     wrap_mode in  1  1 = wrap at the edges, 0 = saturate (block)
//     nxt       out W  position after the request
//     wrapped   out 1  the move crossed an edge and wrapped
//     blocked   out 1  the move was refused at an edge
// ---------------------------------------------------------------------------
module axis_step_counter #(
  parameter int N = 9,
  parameter int W = 4
) (
  input  logic [W-1:0] cur,
  input  logic         en,
  input  logic         up,
  input  logic         req,
  input  logic         wrap_mode,
  output logic [W-1:0] nxt,
  output logic         wrapped,
  output logic         blocked
);

  localparam logic [W-1:0] MAX_POS = W'(N - 1);

  always_comb begin
    // NOTE: every output gets a default before any branch so that no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    nxt     = cur;
    wrapped = 1'b0;
    blocked = 1'b0;
    if (req && en) begin
      if (up) begin
        if (cur == MAX_POS) begin
          if (wrap_mode) begin
            nxt     = '0;
            wrapped = 1'b1;
          end else begin
            blocked = 1'b1;
          end
        end else begin
          nxt = cur + 1'b1;
        end
      end else begin
        if (cur == '0) begin
          if (wrap_mode) begin
            nxt     = MAX_POS;
            wrapped = 1'b1;
          end else begin
            blocked = 1'b1;
          end
        end else begin
          nxt = cur - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cursor_position_counter.sv
// ---------------------------------------------------------------------------
// cursor_position_counter
//   Holds the Sudoku cursor (row, col) on a GRID_N x GRID_N board and moves
//   it one cell per step request along the axes selected by the direction
//   word. Row, col and the linear cell index are registered together so they
//   are always mutually consistent; move/wrap/blocked are one-cycle pulses.
//
//   Ports:
//     clk  in  1   rising-edge clock
//     rst  in  1   synchronous active-high reset
//     bus  slave modport of cursor_position_counter_if
//            dir/step/home in, col/row/cell_idx and the three pulses out
//
//   Optional build macro: CURSOR_AUTOREPEAT_EN
//     When defined, holding step issues an extra request REPEAT_DELAY cycles
//     after the rising edge and then every REPEAT_PERIOD cycles. When not
//     defined, only rising edges of step are requests and the REPEAT_*
//     parameters have no effect.
// ---------------------------------------------------------------------------
module cursor_position_counter
  import sudoku_pkg::*;
#(
  parameter int GRID_N        = GRID_N_DEFAULT,
  parameter int CW            = 4,
  parameter int IW            = 7,
  parameter bit WRAP          = 1'b1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                      clk,
  input  logic                      rst,
  cursor_position_counter_if.slave  bus
);

  // Reject configurations whose outputs cannot hold every legal position.
  if (GRID_N < 2 || (2 ** CW) < GRID_N || (2 ** IW) < GRID_N * GRID_N ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("cursor_position_counter: inconsistent parameters");
  end

  logic [CW-1:0] col_q, row_q;
  logic [IW-1:0] cell_q;
  logic          move_q, wrap_q, blocked_q;
  logic          step_d;

  logic          edge_req, rpt_req, req, move_req;
  logic [CW-1:0] col_n, row_n;
  logic [IW-1:0] cell_n;
  logic          move_n, wrap_n, blocked_n;
  logic [CW-1:0] x_next, y_next;
  logic          x_wrapped, x_blocked, y_wrapped, y_blocked;

  assign edge_req = bus.step & ~step_d;

`ifdef CURSOR_AUTOREPEAT_EN
  // rpt_cnt counts cycles since the last request while step stays high;
  // zero means idle. rpt_phase selects the first-delay or period threshold.
  localparam logic [31:0] DELAY_CNT  = 32'(REPEAT_DELAY);
  localparam logic [31:0] PERIOD_CNT = 32'(REPEAT_PERIOD);

  logic [31:0] rpt_cnt;
  logic        rpt_phase;

  assign rpt_req = bus.step && step_d && (rpt_cnt != '0) &&
                   (rpt_cnt == (rpt_phase ? PERIOD_CNT : DELAY_CNT));

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (!bus.step || bus.home) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (edge_req) begin
      rpt_cnt   <= 32'd1;
      rpt_phase <= 1'b0;
    end else if (rpt_req) begin
      rpt_cnt   <= 32'd1;
      rpt_phase <= 1'b1;
    end else if (rpt_cnt != '0) begin
      rpt_cnt   <= rpt_cnt + 32'd1;
    end
  end
`else
  assign rpt_req = 1'b0;
`endif

  assign req      = edge_req | rpt_req;
  // home outranks a request arriving in the same cycle.
  assign move_req = req & ~bus.home;

  axis_step_counter #(.N(GRID_N), .W(CW)) u_x_axis (
    .cur       (col_q),
    .en        (bus.dir[DIR_X_EN]),
    .up        (bus.dir[DIR_X_UP]),
    .req       (move_req),
    .wrap_mode (WRAP),
    .nxt       (x_next),
    .wrapped   (x_wrapped),
    .blocked   (x_blocked)
  );

  axis_step_counter #(.N(GRID_N), .W(CW)) u_y_axis (
    .cur       (row_q),
    .en        (bus.dir[DIR_Y_EN]),
    .up        (bus.dir[DIR_Y_UP]),
    .req       (move_req),
    .wrap_mode (WRAP),
    .nxt       (y_next),
    .wrapped   (y_wrapped),
    .blocked   (y_blocked)
  );

  always_comb begin
    col_n     = x_next;
    row_n     = y_next;
    move_n    = (x_next != col_q) || (y_next != row_q);
    wrap_n    = x_wrapped | y_wrapped;
    blocked_n = x_blocked | y_blocked;
    if (bus.home) begin
      col_n     = '0;
      row_n     = '0;
      move_n    = (col_q != '0) || (row_q != '0);
      wrap_n    = 1'b0;
      blocked_n = 1'b0;
    end
    // Index comes from the next position so it lands in the same cycle.
    cell_n = IW'(grid_mul(32'(row_n), 32'(GRID_N)) + 32'(col_n));
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      step_d    <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      cell_q    <= '0;
      move_q    <= 1'b0;
      wrap_q    <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      step_d    <= bus.step;
      col_q     <= col_n;
      row_q     <= row_n;
      cell_q    <= cell_n;
      move_q    <= move_n;
      wrap_q    <= wrap_n;
      blocked_q <= blocked_n;
    end
  end

  assign bus.col           = col_q;
  assign bus.row           = row_q;
  assign bus.cell_idx      = cell_q;
  assign bus.move_pulse    = move_q;
  assign bus.wrap_pulse    = wrap_q;
  assign bus.blocked_pulse = blocked_q;

endmodule

// File: tb/tb_cursor_position_counter.sv
// ---------------------------------------------------------------------------
// tb_cursor_position_counter
//   Drives one wrapping (WRAP=1) and one saturating (WRAP=0) instance with
//   the same stimulus and compares every output, every cycle, against an
//   integer board model. Directed scenarios come first, then random traffic.
// ---------------------------------------------------------------------------
module tb_cursor_position_counter;
  import sudoku_pkg::*;

  localparam int N  = 9;
  localparam int RD = 10;
  localparam int RP = 4;

  logic       clk;
  logic       rst;
  logic [3:0] dir;
  logic       step;
  logic       home;

  int n_total = 0;
  int n_bad   = 0;

  cursor_position_counter_if #(.CW(4), .IW(7)) bus_w ();
  cursor_position_counter_if #(.CW(4), .IW(7)) bus_s ();

  assign bus_w.dir  = dir;
  assign bus_w.step = step;
  assign bus_w.home = home;
  assign bus_s.dir  = dir;
  assign bus_s.step = step;
  assign bus_s.home = home;

  cursor_position_counter #(
    .GRID_N(N), .CW(4), .IW(7), .WRAP(1'b1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  cursor_position_counter #(
    .GRID_N(N), .CW(4), .IW(7), .WRAP(1'b0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ([0] = wrapping, [1] = saturating)
  int m_row [2];
  int m_col [2];
  bit m_move[2];
  bit m_wrap[2];
  bit m_blk [2];
  bit m_prev_step;
`ifdef CURSOR_AUTOREPEAT_EN
  bit m_track;
  int m_k;
`endif

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void step_axis(input int v, input bit en, input bit up,
                                    input bit wrapm, output int nv,
                                    output bit wr, output bit bl);
    int t;
    nv = v;
    wr = 1'b0;
    bl = 1'b0;
    if (en) begin
      t = up ? v + 1 : v - 1;
      if (t < 0 || t >= N) begin
        if (wrapm) begin
          nv = (t + N) % N;
          wr = 1'b1;
        end else begin
          bl = 1'b1;
        end
      end else begin
        nv = t;
      end
    end
  endfunction

  task automatic model_edge();
    bit edge_r, rpt, req;
    int nc, nr;
    bit wx, bx, wy, by;
    if (rst) begin
      m_prev_step = 1'b0;
`ifdef CURSOR_AUTOREPEAT_EN
      m_track = 1'b0;
      m_k     = 0;
`endif
      for (int w = 0; w < 2; w++) begin
        m_row[w] = 0; m_col[w] = 0;
        m_move[w] = 0; m_wrap[w] = 0; m_blk[w] = 0;
      end
    end else begin
      edge_r = step && !m_prev_step;
      rpt    = 1'b0;
`ifdef CURSOR_AUTOREPEAT_EN
      // Repeats fire at k = RD, RD+RP, RD+2RP, ... cycles after the edge.
      if (m_track && step) begin
        m_k++;
        if (m_k == RD || (m_k > RD && (m_k - RD) % RP == 0)) rpt = 1'b1;
      end
      if (!step || home) m_track = 1'b0;
      else if (edge_r) begin
        m_track = 1'b1;
        m_k     = 0;
      end
`endif
      req = edge_r || rpt;
      m_prev_step = step;
      for (int w = 0; w < 2; w++) begin
        m_move[w] = 0; m_wrap[w] = 0; m_blk[w] = 0;
        if (home) begin
          m_move[w] = (m_row[w] != 0) || (m_col[w] != 0);
          m_row[w]  = 0;
          m_col[w]  = 0;
        end else if (req) begin
          step_axis(m_col[w], dir[DIR_X_EN], dir[DIR_X_UP], (w == 0), nc, wx, bx);
          step_axis(m_row[w], dir[DIR_Y_EN], dir[DIR_Y_UP], (w == 0), nr, wy, by);
          m_move[w] = (nc != m_col[w]) || (nr != m_row[w]);
          m_wrap[w] = wx || wy;
          m_blk[w]  = bx || by;
          m_col[w]  = nc;
          m_row[w]  = nr;
        end
      end
    end
  endtask

  task automatic check_all();
    check("w_col",   int'(bus_w.col),           m_col[0]);
    check("w_row",   int'(bus_w.row),           m_row[0]);
    check("w_idx",   int'(bus_w.cell_idx),      m_row[0] * N + m_col[0]);
    check("w_move",  int'(bus_w.move_pulse),    int'(m_move[0]));
    check("w_wrap",  int'(bus_w.wrap_pulse),    int'(m_wrap[0]));
    check("w_block", int'(bus_w.blocked_pulse), int'(m_blk[0]));
    check("s_col",   int'(bus_s.col),           m_col[1]);
    check("s_row",   int'(bus_s.row),           m_row[1]);
    check("s_idx",   int'(bus_s.cell_idx),      m_row[1] * N + m_col[1]);
    check("s_move",  int'(bus_s.move_pulse),    int'(m_move[1]));
    check("s_wrap",  int'(bus_s.wrap_pulse),    int'(m_wrap[1]));
    check("s_block", int'(bus_s.blocked_pulse), int'(m_blk[1]));
  endtask

  // Inputs change 1 time unit after the edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_step(input logic [3:0] d);
    dir  = d;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
  endtask

  task automatic go_home();
    home = 1'b1;
    tick();
    home = 1'b0;
    tick();
  endtask

  initial begin
    int moves;
    int exp_moves;

    rst = 1'b1; dir = 4'b0000; step = 1'b0; home = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // One step right from (0,0).
    dir  = 4'b0011;
    step = 1'b1;
    tick();
    check("tp_first_idx", int'(bus_w.cell_idx), 1);
    step = 1'b0;
    tick();

    // Walk to col 8, then one more: wrap on one DUT, block on the other.
    repeat (7) do_step(4'b0011);
    do_step(4'b0011);
    // Row decrement at row 0.
    do_step(4'b0100);
    // Ignored request (no enables).
    do_step(4'b1010);

    // Reach (row 3, col 4), then diagonal up-up to (4,5).
    go_home();
    repeat (3) do_step(4'b1100);
    repeat (4) do_step(4'b0011);
    dir  = 4'b1111;
    step = 1'b1;
    tick();
    check("tp_diag_idx", int'(bus_w.cell_idx), 41);
    step = 1'b0;
    tick();

    // Hold step for 100 cycles and count moves.
    exp_moves = 1;
`ifdef CURSOR_AUTOREPEAT_EN
    for (int k = 1; k < 100; k++)
      if (k == RD || (k > RD && (k - RD) % RP == 0)) exp_moves++;
`endif
    moves = 0;
    dir   = 4'b0011;
    step  = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (bus_w.move_pulse) moves++;
    end
    step = 1'b0;
    tick();
    check("hold_moves", moves, exp_moves);

    // home together with a step request at (5,5).
    go_home();
    repeat (5) do_step(4'b1111);
    dir  = 4'b1111;
    home = 1'b1;
    step = 1'b1;
    tick();
    check("home_step_row", int'(bus_w.row), 0);
    check("home_step_col", int'(bus_w.col), 0);
    home = 1'b0;
    step = 1'b0;
    tick();

    // Reset in the middle of a held step, then release with step still high.
    do_step(4'b0011);
    step = 1'b1;
    tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_hold_col", int'(bus_w.col), 1);
    step = 1'b0;
    tick();

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      dir  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 3) step = ~step;
      home = ($urandom_range(0, 29) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
